// File: rtl/srl_fifo_pkg.sv
// Shared constants and elaboration-time helpers for the SRL-based FIFO.
package srl_fifo_pkg;

    localparam int unsigned MAX_WIDTH = 256;
    localparam int unsigned MAX_DEPTH = 256;

    // Ceiling log2, usable in parameter expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit depth_legal(input int unsigned depth);
        return is_pow2(depth) && (depth >= 2) && (depth <= MAX_DEPTH);
    endfunction

    function automatic bit afull_legal(input int unsigned level, input int unsigned depth);
        return (level >= 1) && (level <= depth);
    endfunction

    function automatic bit width_legal(input int unsigned width);
        return (width >= 1) && (width <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/srl_shift_array.sv
// CE-gated shift storage with an addressable combinational tap; no reset,
// so each bit column maps onto cascaded SRLC16E primitives.
module srl_shift_array
    import srl_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] tap_c,
    output logic [WIDTH-1:0] last_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (ce) begin
            mem[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign tap_c  = mem[addr];
    assign last_c = mem[DEPTH-1];

endmodule

// File: rtl/srl_fifo.sv
// Shift-register FIFO: occupancy counter, flags and zero-masked head read
// around an srl_shift_array.
module srl_fifo
    import srl_fifo_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AFULL_LEVEL = 12,
    localparam int unsigned AW = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow,
    output logic [WIDTH-1:0] cascade_out
);

    if (!depth_legal(DEPTH)) begin : g_bad_depth
        $error("srl_fifo: DEPTH must be a power of two in 2..256");
    end
    if (!afull_legal(AFULL_LEVEL, DEPTH)) begin : g_bad_afull
        $error("srl_fifo: AFULL_LEVEL must be in 1..DEPTH");
    end
    if (!width_legal(WIDTH)) begin : g_bad_width
        $error("srl_fifo: WIDTH must be in 1..256");
    end

    logic             push;
    logic             pop;
    logic [AW:0]      count_nxt;
    logic             overflow_nxt;
    logic             underflow_nxt;
    logic [AW-1:0]    tap_addr;
    logic [WIDTH-1:0] tap_data;

    assign full        = (count == (AW+1)'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= (AW+1)'(AFULL_LEVEL));
    assign wr_ready    = !full;
    assign rd_valid    = !empty;

    assign push     = wr_valid & wr_ready;
    assign pop      = rd_valid & rd_ready;
    assign tap_addr = AW'(count - (AW+1)'(1));
    assign rd_data  = empty ? '0 : tap_data;

    // Clear wins over push, pop and flag setting.
    always_comb begin
        count_nxt     = count;
        overflow_nxt  = overflow | (wr_valid & full);
        underflow_nxt = underflow | (rd_ready & empty);
        if (clear) begin
            count_nxt     = '0;
            overflow_nxt  = 1'b0;
            underflow_nxt = 1'b0;
        end else if (push && !pop) begin
            count_nxt = count + (AW+1)'(1);
        end else if (pop && !push) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_nxt;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
        end
    end

    srl_shift_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_array (
        .clock  (clock),
        .ce     (push & !clear),
        .din    (wr_data),
        .addr   (tap_addr),
        .tap_c  (tap_data),
        .last_c (cascade_out)
    );

endmodule
